// File: rtl/fetch_unit.sv
// Instruction fetch front-end: sequential word fetch with a DEPTH-entry
// {pc, instr} queue, in-order memory responses and redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] filled, filled_n;
  logic [PW-1:0]    alloc_ptr, fill_ptr, read_ptr;
  logic [CW-1:0]    used, drop_cnt, inflight;

  logic [CW-1:0] used_alloc, outstanding, flush_drop;
  logic          req_hs, resp_any, resp_drop, resp_fill, consume;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    used_alloc     = used - drop_cnt;
    // inflight tracks live requests; drop_cnt tracks requests orphaned by redirects
    outstanding    = drop_cnt + inflight;
    imem_req_valid = !reset && !redirect_valid && (used < DEPTH_C);
    imem_req_addr  = fetch_pc;
    instr_valid    = filled[read_ptr] && ((read_ptr != alloc_ptr) || (used_alloc == DEPTH_C));
    instr_data     = data_q[read_ptr];
    instr_pc       = pc_q[read_ptr];
    req_hs         = imem_req_valid && imem_req_ready;
    resp_any       = imem_resp_valid && (outstanding != '0);
    resp_drop      = resp_any && (drop_cnt != '0);
    resp_fill      = resp_any && (drop_cnt == '0);
    consume        = instr_valid && instr_ready;
    flush_drop     = outstanding - CW'(resp_any);
  end

  always_comb begin
    filled_n = filled;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_hs && (alloc_ptr == PW'(i)))   filled_n[i] = 1'b0;
      if (resp_fill && (fill_ptr == PW'(i))) filled_n[i] = 1'b1;
      if (consume && (read_ptr == PW'(i)))   filled_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      used      <= '0;
      drop_cnt  <= '0;
      inflight  <= '0;
      filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= NOP;
      end
    end else if (redirect_valid) begin
      // every outstanding response, except one arriving now, becomes a drop
      fetch_pc  <= {redirect_pc[31:2], 2'b00};
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      filled    <= '0;
      inflight  <= '0;
      drop_cnt  <= flush_drop;
      used      <= flush_drop;
    end else begin
      if (req_hs) begin
        pc_q[alloc_ptr] <= fetch_pc;
        fetch_pc        <= fetch_pc + 32'd4;
        alloc_ptr       <= alloc_ptr + PW'(1);
      end
      if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
      if (resp_fill) begin
        data_q[fill_ptr] <= imem_resp_data;
        fill_ptr         <= fill_ptr + PW'(1);
      end
      if (consume) read_ptr <= read_ptr + PW'(1);
      filled   <= filled_n;
      used     <= used + CW'(req_hs) - CW'(resp_drop) - CW'(consume);
      inflight <= inflight + CW'(req_hs) - CW'(resp_fill);
    end
  end

  orphan_resp: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory emulator plus an epoch-based
// reference model of the delivered {pc, instr} stream and request credits.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr_data, instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  int          tests = 0, fails = 0, cyc = 0;
  pend_t       pend[$];
  int          epoch = 0, buffered = 0;
  logic [31:0] req_exp, exp_pc;
  logic [31:0] req_log[$], pc_log[$], dat_log[$];
  logic        s_iv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h0000_1357;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    redirect_valid = 1'b0; instr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_data", instr_data, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 0);
    reset = 1'b0;
    pend.delete(); req_log.delete(); pc_log.delete(); dat_log.delete();
    epoch++; buffered = 0;
    req_exp = RESET_PC; exp_pc = RESET_PC;
  endtask

  // One cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rreq,
                      input bit rins, input int lat);
    bit exp_rv, exp_iv, resp, fresh;
    int used_m;
    @(negedge clk);
    resp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pend[0].addr) : $urandom;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_req_ready  = rreq;
    instr_ready     = rins;
    #1;
    used_m = pend.size() + buffered;
    exp_rv = !redir && (used_m < DEPTH);
    exp_iv = buffered > 0;
    s_iv   = instr_valid;
    check("used_le_depth", 32'(used_m <= DEPTH), 1);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, req_exp);
    check("instr_valid", instr_valid, exp_iv);
    if (exp_iv) begin
      check("instr_pc", instr_pc, exp_pc);
      check("instr_data", instr_data, mem_word(exp_pc));
    end
    if (resp) begin
      fresh = (pend[0].epoch == epoch);
      void'(pend.pop_front());
      if (fresh) buffered++;
    end
    if (exp_iv && rins) begin
      pc_log.push_back(exp_pc);
      dat_log.push_back(instr_data);
      buffered--;
      exp_pc += 32'd4;
    end
    if (exp_rv && rreq) begin
      req_log.push_back(req_exp);
      pend.push_back('{req_exp, epoch, cyc + lat});
      req_exp += 32'd4;
    end
    if (redir) begin
      epoch++;
      buffered = 0;
      exp_pc  = {rpc[31:2], 2'b00};
      req_exp = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int n;
    // streaming from reset, zero-wait memory
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1);
    check("t1_req0", req_log[0], 32'h0);
    check("t1_req1", req_log[1], 32'h4);
    check("t1_req2", req_log[2], 32'h8);
    check("t1_req3", req_log[3], 32'hC);
    check("t1_pc0", pc_log[0], 32'h0);
    check("t1_pc3", pc_log[3], 32'hC);
    check("t1_data0", dat_log[0], 32'hC3A5_1357);
    check("t1_data1", dat_log[1], 32'hC3A1_1357);
    check("t1_count", pc_log.size(), 6);

    // core stalled: queue fills, then one consume frees one credit
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1);
    check("t2_full_reqs", req_log.size(), 4);
    check("t2_req3", req_log[3], 32'hC);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    check("t2_reqs", req_log.size(), 5);
    check("t2_req4", req_log[4], 32'h10);

    // redirect with two slow requests in flight
    do_reset();
    step(1, 32'h20, 1, 1, 1);
    step(0, 0, 1, 1, 3);
    step(0, 0, 1, 1, 3);
    step(1, 32'h103, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1);
    check("t3_req0", req_log[0], 32'h20);
    check("t3_req1", req_log[1], 32'h24);
    check("t3_req2", req_log[2], 32'h100);
    check("t3_pc0", pc_log[0], 32'h100);
    check("t3_pc1", pc_log[1], 32'h104);

    // redirect coinciding with a response and a consume
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 2);
    n = pc_log.size();
    step(1, 32'h400, 1, 1, 1);
    check("t4_consumed", pc_log.size() - n, 1);
    n = pc_log.size();
    step(0, 0, 1, 1, 1);
    check("t4_empty", s_iv, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 1);
    check("t4_pc0", pc_log[n], 32'h400);

    // address wrap at the top of the space
    do_reset();
    step(1, 32'hFFFF_FFF8, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 1);
    check("t5_req0", req_log[0], 32'hFFFF_FFF8);
    check("t5_req1", req_log[1], 32'hFFFF_FFFC);
    check("t5_req2", req_log[2], 32'h0000_0000);
    check("t5_req3", req_log[3], 32'h0000_0004);

    // random traffic, redirects and one mid-run reset
    do_reset();
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        n += pc_log.size();
        do_reset();
      end
      step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(1, 4));
    end
    n += pc_log.size();
    check("t6_progress", 32'(n > 2000), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
